// File: rtl/qos_vc_buffer.sv
// Two-class virtual-channel buffer: per-class FIFOs feeding one registered valid/ready
// output stage, VC0 strict priority with a burst limit that keeps VC1 moving.
module qos_vc_buffer #(
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int MAX_BURST = 3,
  parameter int W1        = 7,
  parameter int W2        = 7,
  parameter int W3        = 32
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   ENB,
  input  logic                   in_valid,
  input  logic                   in_class,
  input  logic [W1-1:0]          in_1,
  input  logic [W2-1:0]          in_2,
  input  logic [W3-1:0]          in_3,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic                   out_class,
  output logic [W1-1:0]          out_1,
  output logic [W2-1:0]          out_2,
  output logic [W3-1:0]          out_3,
  output logic [$clog2(DEPTH):0] vc0_count,
  output logic [$clog2(DEPTH):0] vc1_count,
  output logic                   vc0_almost_full,
  output logic                   vc1_almost_full,
  output logic                   error
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = W1 + W2 + W3;
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [WW-1:0] mem0_r [DEPTH];
  logic [WW-1:0] mem1_r [DEPTH];
  logic [PW-1:0] wr0_r, rd0_r, wr1_r, rd1_r;
  logic [CW-1:0] cnt0_r, cnt1_r, cnt0_nxt_s, cnt1_nxt_s;
  logic [BW-1:0] burst_r, burst_nxt_s;
  logic [WW-1:0] data_r;
  logic          valid_r, cls_r, af0_r, af1_r, err_r;
  logic          ne0_s, ne1_s, out_valid_s, free_s, grant1_s;
  logic          pop0_s, pop1_s, acc0_s, acc1_s, drop_s;
  logic [WW-1:0] word_s;

  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                               input logic acc, input logic pop);
    logic [CW-1:0] res;
    if (acc && !pop) begin
      res = cnt + CW'(1);
    end else if (!acc && pop) begin
      res = cnt - CW'(1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  // Grant, pop and push-acceptance decisions for this cycle
  always_comb begin
    word_s      = {in_1, in_2, in_3};
    ne0_s       = (cnt0_r != CW'(0));
    ne1_s       = (cnt1_r != CW'(0));
    out_valid_s = ENB & valid_r;
    free_s      = ~valid_r | (out_valid_s & out_ready);
    grant1_s    = ne1_s & (~ne0_s | (burst_r == BW'(MAX_BURST)));
    pop0_s      = ENB & free_s & ne0_s & ~grant1_s;
    pop1_s      = ENB & free_s & grant1_s;
    // A full FIFO still accepts when its head leaves in the same cycle.
    acc0_s      = ENB & in_valid & ~in_class & ((cnt0_r < CW'(DEPTH)) | pop0_s);
    acc1_s      = ENB & in_valid &  in_class & ((cnt1_r < CW'(DEPTH)) | pop1_s);
    drop_s      = ENB & in_valid & ~(acc0_s | acc1_s);
    cnt0_nxt_s  = next_count(cnt0_r, acc0_s, pop0_s);
    cnt1_nxt_s  = next_count(cnt1_r, acc1_s, pop1_s);
  end

  // Burst counter next state: counts VC0 wins only while VC1 is waiting
  always_comb begin
    burst_nxt_s = burst_r;
    if (!ENB) begin
      burst_nxt_s = burst_r;
    end else if (!ne1_s || pop1_s) begin
      burst_nxt_s = BW'(0);
    end else if (pop0_s && (burst_r < BW'(MAX_BURST))) begin
      burst_nxt_s = burst_r + BW'(1);
    end else begin
      burst_nxt_s = burst_r;
    end
  end

  // FIFO storage writes (data array needs no reset; pointers qualify it)
  always_ff @(posedge clk) begin
    if (acc0_s) begin
      mem0_r[wr0_r] <= word_s;
    end
    if (acc1_s) begin
      mem1_r[wr1_r] <= word_s;
    end
  end

  // Pointers, occupancy, flags and burst state
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr0_r   <= PW'(0);
      rd0_r   <= PW'(0);
      wr1_r   <= PW'(0);
      rd1_r   <= PW'(0);
      cnt0_r  <= CW'(0);
      cnt1_r  <= CW'(0);
      af0_r   <= 1'b0;
      af1_r   <= 1'b0;
      err_r   <= 1'b0;
      burst_r <= BW'(0);
    end else begin
      if (acc0_s) wr0_r <= wr0_r + PW'(1);
      if (pop0_s) rd0_r <= rd0_r + PW'(1);
      if (acc1_s) wr1_r <= wr1_r + PW'(1);
      if (pop1_s) rd1_r <= rd1_r + PW'(1);
      cnt0_r  <= cnt0_nxt_s;
      cnt1_r  <= cnt1_nxt_s;
      af0_r   <= (cnt0_nxt_s >= CW'(AF_THRESH));
      af1_r   <= (cnt1_nxt_s >= CW'(AF_THRESH));
      err_r   <= err_r | drop_s;
      burst_r <= burst_nxt_s;
    end
  end

  // Output register: reloads from the granted head whenever it is free
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_r <= 1'b0;
      cls_r   <= 1'b0;
      data_r  <= WW'(0);
    end else if (ENB && free_s) begin
      if (pop0_s || pop1_s) begin
        valid_r <= 1'b1;
        cls_r   <= pop1_s;
        data_r  <= pop1_s ? mem1_r[rd1_r] : mem0_r[rd0_r];
      end else begin
        valid_r <= 1'b0;
      end
    end
  end

  assign out_valid       = out_valid_s;
  assign out_class       = cls_r;
  assign out_1           = data_r[WW-1 -: W1];
  assign out_2           = data_r[W2+W3-1 -: W2];
  assign out_3           = data_r[W3-1:0];
  assign vc0_count       = cnt0_r;
  assign vc1_count       = cnt1_r;
  assign vc0_almost_full = af0_r;
  assign vc1_almost_full = af1_r;
  assign error           = err_r;
endmodule

// File: tb/tb_qos_vc_buffer.sv
// Directed bench for qos_vc_buffer: expected output words queued at stimulus time,
// popped and compared at each output handshake.
module tb_qos_vc_buffer;
  logic        clk = 1'b0;
  logic        reset_L, ENB, in_valid, in_class, out_ready;
  logic [6:0]  in_1, in_2;
  logic [31:0] in_3;
  logic        out_valid, out_class;
  logic [6:0]  out_1, out_2;
  logic [31:0] out_3;
  logic [2:0]  vc0_count, vc1_count;
  logic        vc0_almost_full, vc1_almost_full, error;

  int          compared;
  int          mism;
  int          n;
  logic [46:0] sb[$];

  qos_vc_buffer dut (
    .clk(clk), .reset_L(reset_L), .ENB(ENB), .in_valid(in_valid), .in_class(in_class),
    .in_1(in_1), .in_2(in_2), .in_3(in_3), .out_ready(out_ready),
    .out_valid(out_valid), .out_class(out_class), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .vc0_count(vc0_count), .vc1_count(vc1_count),
    .vc0_almost_full(vc0_almost_full), .vc1_almost_full(vc1_almost_full), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [45:0] mkw(input int k);
    logic [6:0] a;
    a = k[6:0];
    return {a, ~a, 32'hA500_0000 + 32'(k)};
  endfunction

  // Settle, score any handshake about to complete, then advance to the next negedge.
  task automatic step();
    logic [46:0] exp;
    #1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("extra_out_word", 64'(out_valid), 64'd0);
      end else begin
        exp = sb.pop_front();
        chk("out_word", 64'({out_class, out_1, out_2, out_3}), 64'(exp));
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic cls, input logic [45:0] w);
    in_valid = 1'b1;
    in_class = cls;
    {in_1, in_2, in_3} = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget, output int cnt);
    out_ready = 1'b1;
    cnt = 0;
    while (sb.size() != 0 && cnt < budget) begin
      step();
      cnt++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    reset_L = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    compared = 0; mism = 0;
    reset_L = 1'b0; ENB = 1'b1; in_valid = 1'b0; in_class = 1'b0;
    in_1 = 7'd0; in_2 = 7'd0; in_3 = 32'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_counts", 64'({vc0_count, vc1_count}), 64'd0);
    chk("rst_flags", 64'({vc0_almost_full, vc1_almost_full, error}), 64'd0);
    chk("rst_fields", 64'({out_class, out_1, out_2, out_3}), 64'd0);
    reset_L = 1'b1;
    @(negedge clk);

    // Reset asserted mid-stream, between edges
    for (int k = 1; k <= 3; k++) send(1'b0, mkw(k));
    chk("pre_rst_vc0_count", 64'(vc0_count), 64'd2);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2 reset_L = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_vc0_count", 64'(vc0_count), 64'd0);
    chk("async_rst_fields", 64'({out_class, out_1, out_2, out_3}), 64'd0);
    @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);
    chk("post_rst_counts", 64'({vc0_count, vc1_count}), 64'd0);

    // Single VC1 word, two-edge latency
    out_ready = 1'b1;
    sb.push_back({1'b1, 7'h12, 7'h34, 32'hDEADBEEF});
    send(1'b1, {7'h12, 7'h34, 32'hDEADBEEF});
    chk("single_lat1_valid", 64'(out_valid), 64'd0);
    chk("single_vc1_count", 64'(vc1_count), 64'd1);
    step();
    chk("single_lat2_valid", 64'(out_valid), 64'd1);
    chk("single_class", 64'(out_class), 64'd1);
    step();
    chk("single_after_valid", 64'(out_valid), 64'd0);
    chk("single_after_count", 64'(vc1_count), 64'd0);
    chk("single_scored", 64'(sb.size()), 64'd0);

    // Overflow with the consumer stalled
    out_ready = 1'b0;
    send(1'b0, mkw(10));
    send(1'b0, mkw(11));
    send(1'b0, mkw(12));
    chk("ovf_af_two", 64'(vc0_almost_full), 64'd0);
    send(1'b0, mkw(13));
    chk("ovf_af_three", 64'({vc0_count, vc0_almost_full}), 64'({3'd3, 1'b1}));
    send(1'b0, mkw(14));
    chk("ovf_full_noerr", 64'({vc0_count, error}), 64'({3'd4, 1'b0}));
    send(1'b0, mkw(15));
    chk("ovf_drop", 64'({vc0_count, error, out_valid}), 64'({3'd4, 1'b1, 1'b1}));
    for (int k = 10; k <= 14; k++) sb.push_back({1'b0, mkw(k)});
    drain(20, n);
    chk("ovf_drain_cycles", 64'(n), 64'd5);
    step();
    chk("ovf_empty", 64'({vc0_count, vc0_almost_full, out_valid}), 64'd0);
    chk("ovf_err_sticky", 64'(error), 64'd1);
    pulse_reset();
    chk("err_cleared", 64'(error), 64'd0);

    // Full FIFO accepts a push when its head pops in the same cycle
    out_ready = 1'b0;
    for (int k = 20; k <= 24; k++) send(1'b0, mkw(k));
    chk("pwp_full", 64'(vc0_count), 64'd4);
    for (int k = 20; k <= 25; k++) sb.push_back({1'b0, mkw(k)});
    out_ready = 1'b1;
    send(1'b0, mkw(25));
    chk("pwp_count", 64'({vc0_count, error}), 64'({3'd4, 1'b0}));
    drain(20, n);
    chk("pwp_drain_cycles", 64'(n), 64'd5);

    // ENB low freezes everything and blocks the handshake
    out_ready = 1'b0;
    send(1'b1, mkw(30));
    send(1'b1, mkw(31));
    ENB = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_class = 1'b0; {in_1, in_2, in_3} = mkw(99);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("enb_out_valid", 64'(out_valid), 64'd0);
    end
    chk("enb_frozen", 64'({vc0_count, vc1_count, error}), 64'({3'd0, 3'd1, 1'b0}));
    in_valid = 1'b0;
    ENB = 1'b1;
    sb.push_back({1'b1, mkw(30)});
    sb.push_back({1'b1, mkw(31)});
    drain(20, n);
    chk("enb_drain_cycles", 64'(n), 64'd2);

    // Burst limit: register holds A0, then 4 VC1 and 4 VC0 words queued
    out_ready = 1'b0;
    send(1'b0, mkw(40));
    for (int k = 50; k <= 53; k++) send(1'b1, mkw(k));
    for (int k = 41; k <= 44; k++) send(1'b0, mkw(k));
    chk("burst_counts", 64'({vc0_count, vc1_count}), 64'({3'd4, 3'd4}));
    chk("burst_af", 64'({vc0_almost_full, vc1_almost_full}), 64'd3);
    sb.push_back({1'b0, mkw(40)});
    sb.push_back({1'b0, mkw(41)});
    sb.push_back({1'b0, mkw(42)});
    sb.push_back({1'b0, mkw(43)});
    sb.push_back({1'b1, mkw(50)});
    sb.push_back({1'b0, mkw(44)});
    sb.push_back({1'b1, mkw(51)});
    sb.push_back({1'b1, mkw(52)});
    sb.push_back({1'b1, mkw(53)});
    drain(30, n);
    chk("burst_tput_cycles", 64'(n), 64'd9);
    step();
    chk("burst_empty", 64'({vc0_count, vc1_count, out_valid}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
